fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_pkg.sv | 17 +
 rtl/fetch_if.sv | 32 +++
 rtl/fetch_queue.sv | 73 +++++++
 rtl/fetch_unit.sv | 102 ++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-path constants and types: fetch group width, queue depth, reset PC, word-address width.
// No logic; pure declarations.
// No backpressure; declarations only.
package cpu_pkg;
    localparam int FETCH_WIDTH = 4;
    localparam int WADDR_W     = 15;
    localparam int QDEPTH      = 8;
    localparam logic [WADDR_W-1:0] RESET_PC = '0;

    typedef logic [WADDR_W-1:0] waddr_t;
    typedef logic [15:0]        inst_t;

    typedef struct packed {
        inst_t  inst;
        waddr_t pc;
    } qentry_t;
endpackage

// File: rtl/fetch_if.sv
// Fetch unit bus: instruction-memory lanes, redirect, and instruction-queue head window.
// No logic; combinational wiring only.
// Memory backpressure via fetch_stall; downstream consumes via take.
interface fetch_if;
    import cpu_pkg::*;

    waddr_t          fetch_addr0, fetch_addr1, fetch_addr2, fetch_addr3;
    logic            fetch_stall;
    inst_t           fetch_data0, fetch_data1, fetch_data2, fetch_data3;
    logic            redirect;
    waddr_t          redirect_pc;
    logic [3:0]      out_valid;
    inst_t           out_inst0, out_inst1, out_inst2, out_inst3;
    waddr_t          out_pc0, out_pc1, out_pc2, out_pc3;
    logic [2:0]      take;

    modport master (
        output fetch_addr0, fetch_addr1, fetch_addr2, fetch_addr3, fetch_stall,
        input  fetch_data0, fetch_data1, fetch_data2, fetch_data3,
        input  redirect, redirect_pc, take,
        output out_valid, out_inst0, out_inst1, out_inst2, out_inst3,
        output out_pc0, out_pc1, out_pc2, out_pc3
    );

    modport slave (
        input  fetch_addr0, fetch_addr1, fetch_addr2, fetch_addr3, fetch_stall,
        output fetch_data0, fetch_data1, fetch_data2, fetch_data3,
        output redirect, redirect_pc, take,
        input  out_valid, out_inst0, out_inst1, out_inst2, out_inst3,
        input  out_pc0, out_pc1, out_pc2, out_pc3
    );
endinterface

// File: rtl/fetch_queue.sv
// Circular instruction queue: 4-wide enqueue, up to 4-wide dequeue, synchronous flush.
// Latency: enqueued entries visible on outputs the cycle after the write edge.
// Backpressure: enq_rdy low when the group would not fit after this cycle's dequeue.
module fetch_queue import cpu_pkg::*; #(
    parameter int QDEPTH = cpu_pkg::QDEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   enq_vld,
    input  qentry_t                enq_dat [FETCH_WIDTH],
    input  logic [2:0]             take,
    output logic                   enq_rdy,
    output logic [FETCH_WIDTH-1:0] out_vld,
    output qentry_t                out_dat [FETCH_WIDTH]
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH + 1);

    qentry_t       mem_q [QDEPTH];
    qentry_t       mem_d [QDEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] eff_take;

    always_comb begin
        eff_take = (CW'(take) > count_q) ? count_q : CW'(take);
        enq_rdy  = (int'(count_q) - int'(eff_take) + FETCH_WIDTH) <= QDEPTH;
        mem_d    = mem_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = PW'((int'(head_q) + int'(eff_take)) % QDEPTH);
            count_d = count_q - eff_take;
            if (enq_vld && enq_rdy) begin
                for (int k = 0; k < FETCH_WIDTH; k++) begin
                    mem_d[PW'((int'(tail_q) + k) % QDEPTH)] = enq_dat[k];
                end
                tail_d  = PW'((int'(tail_q) + FETCH_WIDTH) % QDEPTH);
                count_d = count_d + CW'(FETCH_WIDTH);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: count gates visibility.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            out_vld[k] = int'(count_q) > k;
            out_dat[k] = mem_q[PW'((int'(head_q) + k) % QDEPTH)];
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Fetch control: issues 4-word groups to memory, tracks the in-flight group, feeds fetch_queue.
// Latency: address cycle N, enqueue at end of N+1, out_valid[0] at N+2.
// Backpressure: fetch_stall holds memory when the queue cannot take the in-flight group.
module fetch_unit import cpu_pkg::*; #(
    parameter int     QDEPTH   = cpu_pkg::QDEPTH,
    parameter waddr_t RESET_PC = cpu_pkg::RESET_PC
) (
    input logic      clk,
    input logic      reset,
    fetch_if.master  bus
);
    waddr_t                 fetch_pc_q, fetch_pc_d;
    waddr_t                 inflight_pc_q, inflight_pc_d;
    logic                   inflight_vld_q, inflight_vld_d;
    waddr_t                 base_pc;
    logic                   fetch_stall;
    logic                   enq_vld, enq_rdy, flush;
    inst_t                  fetch_dat [FETCH_WIDTH];
    qentry_t                enq_dat [FETCH_WIDTH];
    qentry_t                out_dat [FETCH_WIDTH];
    logic [FETCH_WIDTH-1:0] q_vld;

    assign fetch_dat[0] = bus.fetch_data0;
    assign fetch_dat[1] = bus.fetch_data1;
    assign fetch_dat[2] = bus.fetch_data2;
    assign fetch_dat[3] = bus.fetch_data3;

    always_comb begin
        fetch_pc_d     = fetch_pc_q;
        inflight_pc_d  = inflight_pc_q;
        inflight_vld_d = inflight_vld_q;
        base_pc        = fetch_pc_q;
        fetch_stall    = 1'b0;
        enq_vld        = 1'b0;
        flush          = 1'b0;
        if (reset) begin
            base_pc = RESET_PC;
        end else if (redirect_active()) begin
            base_pc        = bus.redirect_pc;
            flush          = 1'b1;
            inflight_vld_d = 1'b1;
            inflight_pc_d  = bus.redirect_pc;
            fetch_pc_d     = bus.redirect_pc + waddr_t'(FETCH_WIDTH);
        end else if (inflight_vld_q && !enq_rdy) begin
            // Memory keeps its latched group, so report those addresses while stalled.
            base_pc     = inflight_pc_q;
            fetch_stall = 1'b1;
        end else begin
            enq_vld        = inflight_vld_q;
            inflight_vld_d = 1'b1;
            inflight_pc_d  = fetch_pc_q;
            fetch_pc_d     = fetch_pc_q + waddr_t'(FETCH_WIDTH);
        end
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            enq_dat[k].inst = fetch_dat[k];
            enq_dat[k].pc   = inflight_pc_q + waddr_t'(k);
        end
    end

    function automatic logic redirect_active();
        return bus.redirect;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q     <= RESET_PC;
            inflight_pc_q  <= RESET_PC;
            inflight_vld_q <= 1'b0;
        end else begin
            fetch_pc_q     <= fetch_pc_d;
            inflight_pc_q  <= inflight_pc_d;
            inflight_vld_q <= inflight_vld_d;
        end
    end

    fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .enq_vld (enq_vld),
        .enq_dat (enq_dat),
        .take    (bus.take),
        .enq_rdy (enq_rdy),
        .out_vld (q_vld),
        .out_dat (out_dat)
    );

    assign bus.fetch_stall = fetch_stall;
    assign bus.fetch_addr0 = base_pc;
    assign bus.fetch_addr1 = base_pc + waddr_t'(1);
    assign bus.fetch_addr2 = base_pc + waddr_t'(2);
    assign bus.fetch_addr3 = base_pc + waddr_t'(3);
    assign bus.out_valid   = reset ? '0 : q_vld;
    assign bus.out_inst0   = out_dat[0].inst;
    assign bus.out_inst1   = out_dat[1].inst;
    assign bus.out_inst2   = out_dat[2].inst;
    assign bus.out_inst3   = out_dat[3].inst;
    assign bus.out_pc0     = out_dat[0].pc;
    assign bus.out_pc1     = out_dat[1].pc;
    assign bus.out_pc2     = out_dat[2].pc;
    assign bus.out_pc3     = out_dat[3].pc;
endmodule
